// File: rtl/adcfifo_pkg.sv
// rtl/adcfifo_pkg.sv - shared constants and types for the ADC sample-buffer FIFO controller
package adcfifo_pkg;

    localparam int FIFO_WIDTH      = 32;
    localparam int FIFO_AW         = 7;
    localparam int FIFO_DEPTH      = 2 ** FIFO_AW;
    localparam int FIFO_AFULL_LVL  = 120;
    localparam int FIFO_AEMPTY_LVL = 8;

    // Occupancy needs one bit more than the address to represent a full buffer
    typedef logic [FIFO_AW:0] fifo_count_t;

endpackage

// File: rtl/adcfifo_rdvld_pipe.sv
// rtl/adcfifo_rdvld_pipe.sv - read-valid delay line matching the RAM read latency
module adcfifo_rdvld_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic in_vld,
    output logic out_vld
);

    logic [RD_LAT-1:0] vld_sr;

    // Shift accepted pops toward the output; reset discards every pending strobe
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | RD_LAT'(in_vld);
        end
    end

    assign out_vld = vld_sr[RD_LAT-1];

endmodule

// File: rtl/adcfifo_ctrl.sv
// rtl/adcfifo_ctrl.sv - single-clock FIFO controller for the 32x128 ADC sample-buffer LSRAM
module adcfifo_ctrl
    import adcfifo_pkg::*;
#(
    parameter int WIDTH      = FIFO_WIDTH,
    parameter int AW         = FIFO_AW,
    parameter int AFULL_LVL  = FIFO_AFULL_LVL,
    parameter int AEMPTY_LVL = FIFO_AEMPTY_LVL,
    parameter int RD_LAT     = 1
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             WE,
    input  logic [WIDTH-1:0] DATA,
    input  logic             RE,
    output logic [WIDTH-1:0] Q,
    output logic             DVLD,
    output logic             FULL,
    output logic             EMPTY,
    output logic             AFULL,
    output logic             AEMPTY,
    output logic             OVERFLOW,
    output logic             UNDERFLOW,
    output logic [AW:0]      WRCNT,
    output logic [WIDTH-1:0] RAM_WDATA,
    output logic [AW-1:0]    RAM_WADDR,
    output logic             RAM_WEN,
    output logic [AW-1:0]    RAM_RADDR,
    output logic             RAM_REN,
    input  logic [WIDTH-1:0] RAM_RDATA
);

    localparam int DEPTH = 2 ** AW;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          wr_ok;
    logic          rd_ok;

    // Accept against the registered flags; nothing reaches the RAM while reset is held
    always_comb begin
        wr_ok = WE & ~FULL & RESET_N;
        rd_ok = RE & ~EMPTY & RESET_N;
    end

    // Next occupancy: a simultaneous accepted push and pop cancel out
    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally at DEPTH because their width is exactly AW
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + AW'(1);
            if (rd_ok) rptr <= rptr + AW'(1);
        end
    end

    // Occupancy and flags are registered from next-count so they line up with WRCNT
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            count  <= '0;
            FULL   <= 1'b0;
            EMPTY  <= 1'b1;
            AFULL  <= 1'b0;
            AEMPTY <= 1'b1;
        end else begin
            count  <= count_next;
            FULL   <= (count_next == (AW+1)'(DEPTH));
            EMPTY  <= (count_next == '0);
            AFULL  <= (count_next >= (AW+1)'(AFULL_LVL));
            AEMPTY <= (count_next <= (AW+1)'(AEMPTY_LVL));
        end
    end

    // Rejected requests produce a one-cycle pulse the following cycle
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            OVERFLOW  <= WE & FULL;
            UNDERFLOW <= RE & EMPTY;
        end
    end

    adcfifo_rdvld_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rdvld_pipe (
        .clk     (CLOCK),
        .resetn  (RESET_N),
        .in_vld  (rd_ok),
        .out_vld (DVLD)
    );

    // RAM side is a direct view of the pointers and accept strobes
    always_comb begin
        RAM_WDATA = DATA;
        RAM_WADDR = wptr;
        RAM_WEN   = wr_ok;
        RAM_RADDR = rptr;
        RAM_REN   = rd_ok;
        Q         = RAM_RDATA;
        WRCNT     = count;
    end

endmodule
